// File: rtl/i2c_slave.sv
// I2C slave controller on an 8-bit Wishbone bus: programmable 7-bit address, RXR/TXR data
// registers, SCL stretching while software services data, interrupt on every transfer event.
module i2c_slave_top #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StIgnore
  } state_e;

  localparam logic [3:0] CntMax = 4'(FILT_LEN - 1);

  // Index 0 is SCL, index 1 is SDA; idle bus level is high.
  logic [1:0]      pad_in;
  logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][3:0] cnt_q;

  assign pad_in = {sda_pad_i, scl_pad_i};

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, sda_f, start_det, stop_det;

  assign scl_rise  = filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] & prev_q[0];
  assign sda_f     = filt_q[1];
  assign start_det = filt_q[0] & ~filt_q[1] & prev_q[1];
  assign stop_det  = filt_q[0] & filt_q[1] & ~prev_q[1];

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q, rxr_q, txr_q, dat_q;
  logic [6:0] sadr_q;
  logic       en_q, ien_q, rxf_q, txe_q, rxack_q, busy_q, aas_q, rw_q, sto_q, irq_q;
  logic       scl_oen_q, sda_oen_q, pend_q, ack_q, inta_q;

  logic       wb_acc, wb_wr, wb_rd, en_nxt;
  logic [7:0] sr, rdata;

  assign wb_acc = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_wr  = wb_acc & wb_we_i;
  assign wb_rd  = wb_acc & ~wb_we_i;
  // Clearing en acts on the same edge as the register write.
  assign en_nxt = (wb_wr && wb_adr_i == 3'd1) ? wb_dat_i[7] : en_q;
  assign sr     = {rxack_q, busy_q, aas_q, rw_q, rxf_q, txe_q, sto_q, irq_q};

  always_comb begin
    rdata = 8'h00;
    case (wb_adr_i)
      3'd0:    rdata = {1'b0, sadr_q};
      3'd1:    rdata = {en_q, ien_q, 6'b0};
      3'd2:    rdata = rxr_q;
      3'd3:    rdata = sr;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rxr_q     <= '0;
      txr_q     <= '0;
      dat_q     <= '0;
      sadr_q    <= '0;
      en_q      <= 1'b0;
      ien_q     <= 1'b0;
      rxf_q     <= 1'b0;
      txe_q     <= 1'b0;
      rxack_q   <= 1'b0;
      busy_q    <= 1'b0;
      aas_q     <= 1'b0;
      rw_q      <= 1'b0;
      sto_q     <= 1'b0;
      irq_q     <= 1'b0;
      scl_oen_q <= 1'b1;
      sda_oen_q <= 1'b1;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      inta_q    <= 1'b0;
    end else begin
      ack_q  <= wb_acc;
      dat_q  <= rdata;
      inta_q <= irq_q & ien_q;
      en_q   <= en_nxt;

      if (wb_wr) begin
        case (wb_adr_i)
          3'd0: sadr_q <= wb_dat_i[6:0];
          3'd1: ien_q <= wb_dat_i[6];
          3'd2: begin
            txr_q <= wb_dat_i;
            txe_q <= 1'b0;
          end
          3'd3: if (wb_dat_i[0]) irq_q <= 1'b0;
          default: ;
        endcase
      end
      if (wb_rd && wb_adr_i == 3'd2) rxf_q <= 1'b0;

      if (start_det)     busy_q <= 1'b1;
      else if (stop_det) busy_q <= 1'b0;

      // Bus-side updates come last so a simultaneous flag set wins over a software clear.
      if (!en_nxt) begin
        state_q   <= StIdle;
        scl_oen_q <= 1'b1;
        sda_oen_q <= 1'b1;
        aas_q     <= 1'b0;
        pend_q    <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        scl_oen_q <= 1'b1;
        sda_oen_q <= 1'b1;
        pend_q    <= 1'b0;
        aas_q     <= 1'b0;
        if (aas_q) begin
          sto_q <= 1'b1;
          irq_q <= 1'b1;
        end
      end else if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        aas_q     <= 1'b0;
        sto_q     <= 1'b0;
        scl_oen_q <= 1'b1;
        sda_oen_q <= 1'b1;
        pend_q    <= 1'b0;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == sadr_q) begin
                state_q   <= StAddrAck;
                sda_oen_q <= 1'b0;
                aas_q     <= 1'b1;
                rw_q      <= shift_q[0];
                irq_q     <= 1'b1;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              sda_oen_q <= 1'b1;
              bit_cnt_q <= '0;
              if (rw_q) begin
                // First read byte always waits for a fresh TXR write.
                state_q   <= StTx;
                txe_q     <= 1'b1;
                scl_oen_q <= 1'b0;
                pend_q    <= 1'b1;
              end else begin
                state_q <= StRx;
              end
            end
          end
          StRx: begin
            if (pend_q) begin
              if (!rxf_q) begin
                rxr_q     <= shift_q;
                rxf_q     <= 1'b1;
                irq_q     <= 1'b1;
                sda_oen_q <= 1'b0;
                scl_oen_q <= 1'b1;
                pend_q    <= 1'b0;
                state_q   <= StRxAck;
              end
            end else if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              // Hold SCL until RXR is free; released next cycle if it already is.
              scl_oen_q <= 1'b0;
              pend_q    <= 1'b1;
            end
          end
          StRxAck: begin
            if (scl_fall) begin
              sda_oen_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= StRx;
            end
          end
          StTx: begin
            if (pend_q) begin
              if (!txe_q) begin
                shift_q   <= txr_q;
                txe_q     <= 1'b1;
                irq_q     <= 1'b1;
                sda_oen_q <= txr_q[7];
                bit_cnt_q <= 4'd1;
                scl_oen_q <= 1'b1;
                pend_q    <= 1'b0;
              end
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oen_q <= 1'b1;
                state_q   <= StTxAck;
              end else begin
                sda_oen_q <= shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StTxAck: begin
            if (scl_rise) begin
              rxack_q <= sda_f;
            end else if (scl_fall) begin
              if (rxack_q) begin
                state_q <= StIgnore;
              end else begin
                state_q   <= StTx;
                scl_oen_q <= 1'b0;
                pend_q    <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_inta_o    = inta_q;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen_q;
  assign sda_padoen_o = sda_oen_q;

endmodule
